// File: rtl/maria_pkg.sv
// maria_pkg: shared types and constants for the Maria line RAM DMA path
package maria_pkg;
    localparam int HDR_ADDR_W = 16;
    localparam int WIDTH_ZERO_BYTES = 32;
    typedef enum logic [2:0] {
        IDLE, LOAD, FETCH, WRITE, DRAIN, ABORT_WAIT, SWAP, DONE
    } lram_seq_state_t;
    typedef struct packed {
        logic [HDR_ADDR_W-1:0] addr;
        logic [4:0] width;
        logic [2:0] palette;
        logic [7:0] hpos;
        logic wm;
        logic last;
    } dl_header_t;
    function automatic logic [5:0] obj_bytes(input logic [4:0] width);
        return width == 5'd0 ? 6'(WIDTH_ZERO_BYTES) : {1'b0, width};
    endfunction
endpackage

// File: rtl/lram_byte_budget.sv
// lram_byte_budget: per-line fetched-byte counter with sticky budget flag
module lram_byte_budget #(
    parameter int LINE_BUDGET = 128
) (
    input  logic SYSCLK,
    input  logic RESET,
    input  logic inc,
    input  logic clr,
    output logic at_limit,
    output logic budget_hit
);
    logic [7:0] count;
    assign at_limit = inc && (count + 8'd1 == 8'(LINE_BUDGET));
    always_ff @(posedge SYSCLK or posedge RESET)
        if (RESET) begin
            count <= '0;
            budget_hit <= 1'b0;
        end else begin
            count <= clr ? 8'd0 : count + {7'd0, inc};
            budget_hit <= clr ? 1'b0 : budget_hit | at_limit;
        end
endmodule

// File: rtl/lram_dma_sequencer.sv
// lram_dma_sequencer: fetches display-list object bytes and writes them to the line RAM
module lram_dma_sequencer
    import maria_pkg::*;
#(
    parameter int ADDR_W = HDR_ADDR_W,
    parameter int LINE_BUDGET = 128
) (
    input  logic SYSCLK,
    input  logic RESET,
    input  logic LINE_START,
    input  logic DMA_EN,
    input  logic HDR_VALID,
    output logic HDR_READY,
    input  logic [ADDR_W-1:0] HDR_ADDR,
    input  logic [4:0] HDR_WIDTH,
    input  logic [2:0] HDR_PALETTE,
    input  logic [7:0] HDR_HPOS,
    input  logic HDR_WM,
    input  logic HDR_LAST,
    output logic MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic MEM_ACK,
    input  logic [7:0] MEM_DATA,
    output logic [7:0] INPUT_ADDR,
    output logic [2:0] PALETTE,
    output logic [7:0] PIXELS,
    output logic WM,
    output logic INPUT_W,
    output logic PALETTE_W,
    output logic WM_W,
    output logic PIXELS_W,
    output logic LRAM_SWAP,
    output logic BUSY,
    output logic OVERRUN,
    output logic BUDGET_HIT
);
    lram_seq_state_t state, state_nxt;
    dl_header_t hdr;
    logic [5:0] idx;
    logic [7:0] pix;
    logic hs, at_limit, overrun_ls;
    assign hs = HDR_VALID && HDR_READY;
    assign overrun_ls = LINE_START && (state inside {LOAD, FETCH, WRITE, DRAIN});
    lram_byte_budget #(.LINE_BUDGET(LINE_BUDGET)) u_budget (
        .SYSCLK(SYSCLK),
        .RESET(RESET),
        .inc(state == WRITE),
        .clr(state == SWAP),
        .at_limit(at_limit),
        .budget_hit(BUDGET_HIT)
    );
    always_ff @(posedge SYSCLK or posedge RESET)
        if (RESET) state <= DONE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = LINE_START ? SWAP : hs ? LOAD : IDLE;
            LOAD:       state_nxt = LINE_START ? SWAP : FETCH;
            // an overrun that coincides with the ack has nothing left to wait for
            FETCH:      state_nxt = LINE_START ? (MEM_ACK ? SWAP : ABORT_WAIT) : MEM_ACK ? WRITE : FETCH;
            WRITE:      state_nxt = LINE_START ? SWAP
                                  : at_limit ? (hdr.last ? DONE : DRAIN)
                                  : idx + 6'd1 != obj_bytes(hdr.width) ? FETCH
                                  : hdr.last ? DONE : IDLE;
            DRAIN:      state_nxt = LINE_START ? SWAP : hs && HDR_LAST ? DONE : DRAIN;
            ABORT_WAIT: state_nxt = MEM_ACK ? SWAP : ABORT_WAIT;
            SWAP:       state_nxt = IDLE;
            DONE:       state_nxt = LINE_START ? SWAP : DONE;
            default:    state_nxt = DONE;
        endcase
    end
    always_ff @(posedge SYSCLK or posedge RESET)
        if (RESET) begin
            hdr <= '0;
            idx <= '0;
            pix <= '0;
            OVERRUN <= 1'b0;
        end else begin
            OVERRUN <= OVERRUN | overrun_ls;
            if (state == IDLE && hs) begin
                hdr <= '{addr: HDR_ADDR_W'(HDR_ADDR), width: HDR_WIDTH, palette: HDR_PALETTE,
                         hpos: HDR_HPOS, wm: HDR_WM, last: HDR_LAST};
                idx <= '0;
            end
            if (state == FETCH && MEM_ACK) pix <= MEM_DATA;
            if (state == WRITE) idx <= idx + 6'd1;
        end
    always_comb begin
        HDR_READY = (state == IDLE && DMA_EN) || state == DRAIN;
        MEM_REQ = state == FETCH || state == ABORT_WAIT;
        MEM_ADDR = MEM_REQ ? ADDR_W'(hdr.addr + HDR_ADDR_W'(idx)) : '0;
        INPUT_W = state == LOAD;
        PALETTE_W = state == LOAD;
        WM_W = state == LOAD;
        INPUT_ADDR = INPUT_W ? hdr.hpos : 8'd0;
        PALETTE = INPUT_W ? hdr.palette : 3'd0;
        WM = INPUT_W && hdr.wm;
        PIXELS_W = state == WRITE;
        PIXELS = PIXELS_W ? pix : 8'd0;
        LRAM_SWAP = state == SWAP;
        BUSY = !(state inside {IDLE, DONE});
    end
endmodule

// File: tb/tb_lram_dma_sequencer.sv
// tb_lram_dma_sequencer: directed scanlines checked against a transaction-level model
module tb_lram_dma_sequencer;
    localparam int BUDGET = 40;
    logic SYSCLK = 1'b0, RESET, LINE_START, DMA_EN, HDR_VALID, HDR_READY;
    logic [15:0] HDR_ADDR, MEM_ADDR;
    logic [4:0] HDR_WIDTH;
    logic [2:0] HDR_PALETTE, PALETTE;
    logic [7:0] HDR_HPOS, MEM_DATA, INPUT_ADDR, PIXELS;
    logic HDR_WM, HDR_LAST, MEM_REQ, MEM_ACK, WM, INPUT_W, PALETTE_W, WM_W, PIXELS_W;
    logic LRAM_SWAP, BUSY, OVERRUN, BUDGET_HIT;
    int total = 0, bad = 0, cyc = 0, wcnt = 0, wait_n = 0;
    int m_cnt;
    logic m_stop;
    logic [11:0] exp_load[$];
    logic [15:0] exp_fetch[$], addr_log[$];
    logic [7:0] exp_pix[$];
    int acc_log[$], load_log[$], req_log[$], ack_log[$], pix_log[$], swap_log[$];
    logic prev_req = 1'b0, prev_ack = 1'b0;
    logic [15:0] prev_addr = '0;

    lram_dma_sequencer #(.ADDR_W(16), .LINE_BUDGET(BUDGET)) dut (
        .SYSCLK(SYSCLK), .RESET(RESET), .LINE_START(LINE_START), .DMA_EN(DMA_EN),
        .HDR_VALID(HDR_VALID), .HDR_READY(HDR_READY), .HDR_ADDR(HDR_ADDR),
        .HDR_WIDTH(HDR_WIDTH), .HDR_PALETTE(HDR_PALETTE), .HDR_HPOS(HDR_HPOS),
        .HDR_WM(HDR_WM), .HDR_LAST(HDR_LAST), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
        .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA), .INPUT_ADDR(INPUT_ADDR), .PALETTE(PALETTE),
        .PIXELS(PIXELS), .WM(WM), .INPUT_W(INPUT_W), .PALETTE_W(PALETTE_W), .WM_W(WM_W),
        .PIXELS_W(PIXELS_W), .LRAM_SWAP(LRAM_SWAP), .BUSY(BUSY), .OVERRUN(OVERRUN),
        .BUDGET_HIT(BUDGET_HIT)
    );

    always #5 SYSCLK = ~SYSCLK;
    always @(posedge SYSCLK) cyc <= cyc + 1;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // memory slave: acknowledges after wait_n request cycles
    assign MEM_ACK = MEM_REQ && (wcnt >= wait_n);
    assign MEM_DATA = MEM_ACK ? mem_byte(MEM_ADDR) : 8'h00;
    always @(posedge SYSCLK) wcnt <= (!RESET && MEM_REQ && !MEM_ACK) ? wcnt + 1 : 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge SYSCLK) begin
        if (RESET) begin
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (HDR_VALID && HDR_READY) acc_log.push_back(cyc);
            chk("strobe_align", 32'({PALETTE_W, WM_W}), 32'({INPUT_W, INPUT_W}));
            chk("swap_with_pix", 32'(LRAM_SWAP && PIXELS_W), 0);
            if (INPUT_W) begin
                load_log.push_back(cyc);
                chk("load_pending", 32'(exp_load.size() > 0), 1);
                if (exp_load.size() > 0) chk("load", 32'({INPUT_ADDR, PALETTE, WM}), 32'(exp_load.pop_front()));
            end
            if (MEM_REQ && !prev_req) req_log.push_back(cyc);
            if (prev_req && !prev_ack) begin
                chk("req_hold", 32'(MEM_REQ), 1);
                chk("addr_hold", 32'(MEM_ADDR), 32'(prev_addr));
            end
            if (MEM_REQ && MEM_ACK) begin
                ack_log.push_back(cyc);
                addr_log.push_back(MEM_ADDR);
                chk("fetch_pending", 32'(exp_fetch.size() > 0), 1);
                if (exp_fetch.size() > 0) chk("fetch_addr", 32'(MEM_ADDR), 32'(exp_fetch.pop_front()));
            end
            if (PIXELS_W) begin
                pix_log.push_back(cyc);
                chk("pix_pending", 32'(exp_pix.size() > 0), 1);
                if (exp_pix.size() > 0) chk("pixels", 32'(PIXELS), 32'(exp_pix.pop_front()));
            end
            if (LRAM_SWAP) swap_log.push_back(cyc);
            prev_req = MEM_REQ;
            prev_ack = MEM_ACK;
            prev_addr = MEM_ADDR;
        end
    end

    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic new_line();
        acc_log.delete(); load_log.delete(); req_log.delete(); ack_log.delete();
        pix_log.delete(); swap_log.delete(); addr_log.delete();
        m_cnt = 0;
        m_stop = 1'b0;
        LINE_START = 1'b1;
        tick();
        LINE_START = 1'b0;
    endtask

    // object expectations: one load, then one fetch+pixel per byte until the line budget runs out
    task automatic model_hdr(input logic [15:0] a, input logic [4:0] w, input logic [2:0] p,
                             input logic [7:0] hp, input logic wm);
        int n;
        logic [15:0] ad;
        if (m_stop) return;
        exp_load.push_back({hp, p, wm});
        n = (w == 5'd0) ? 32 : int'(w);
        for (int k = 0; k < n; k++) begin
            ad = a + 16'(k);
            exp_fetch.push_back(ad);
            exp_pix.push_back(mem_byte(ad));
            m_cnt++;
            if (m_cnt == BUDGET) begin
                m_stop = 1'b1;
                break;
            end
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [4:0] w, input logic [2:0] p,
                        input logic [7:0] hp, input logic wm, input logic last);
        int n = 0;
        HDR_ADDR = a; HDR_WIDTH = w; HDR_PALETTE = p; HDR_HPOS = hp; HDR_WM = wm; HDR_LAST = last;
        HDR_VALID = 1'b1;
        @(negedge SYSCLK);
        while (!HDR_READY && n < 1000) begin
            @(negedge SYSCLK);
            n++;
        end
        chk("hdr_accept", 32'(HDR_READY), 1);
        @(posedge SYSCLK);
        #1 HDR_VALID = 1'b0;
    endtask

    task automatic hdr(input logic [15:0] a, input logic [4:0] w, input logic [2:0] p,
                       input logic [7:0] hp, input logic wm, input logic last);
        model_hdr(a, w, p, hp, wm);
        send(a, w, p, hp, wm, last);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 2000) begin
            tick();
            n++;
        end
        chk("busy_low", 32'(BUSY), 0);
    endtask

    task automatic queues_empty();
        chk("load_left", 32'(exp_load.size()), 0);
        chk("fetch_left", 32'(exp_fetch.size()), 0);
        chk("pix_left", 32'(exp_pix.size()), 0);
    endtask

    initial begin
        RESET = 1'b1; LINE_START = 1'b0; DMA_EN = 1'b1; HDR_VALID = 1'b1;
        HDR_ADDR = '0; HDR_WIDTH = '0; HDR_PALETTE = '0; HDR_HPOS = '0; HDR_WM = 1'b0; HDR_LAST = 1'b0;
        repeat (3) tick();
        chk("rst_addr", {MEM_ADDR, INPUT_ADDR, PIXELS}, 0);
        chk("rst_ctl", 32'({HDR_READY, MEM_REQ, PALETTE, WM, INPUT_W, PALETTE_W, WM_W, PIXELS_W,
                            LRAM_SWAP, BUSY, OVERRUN, BUDGET_HIT}), 0);
        RESET = 1'b0;
        repeat (2) tick();
        chk("no_hdr_before_line", 32'({HDR_READY, MEM_REQ, BUSY}), 0);
        HDR_VALID = 1'b0;

        // single 3-byte object, zero-wait memory
        new_line();
        hdr(16'h1234, 5'd3, 3'd5, 8'h10, 1'b0, 1'b1);
        wait_idle();
        queues_empty();
        chk("l1_swaps", 32'(swap_log.size()), 1);
        chk("l1_pix_count", 32'(pix_log.size()), 3);
        chk("l1_addr0", 32'(addr_log[0]), 32'h1234);
        chk("l1_addr2", 32'(addr_log[2]), 32'h1236);
        chk("l1_load_lat", 32'(load_log[0] - acc_log[0]), 1);
        chk("l1_req_lat", 32'(req_log[0] - acc_log[0]), 2);
        chk("l1_byte_cost", 32'(pix_log[1] - pix_log[0]), 2);
        chk("l1_done", 32'(HDR_READY), 0);

        // 32-byte object wrapping the address space
        new_line();
        hdr(16'hFFF0, 5'd0, 3'd2, 8'h00, 1'b1, 1'b1);
        wait_idle();
        queues_empty();
        chk("l2_pix_count", 32'(pix_log.size()), 32);
        chk("l2_addr15", 32'(addr_log[15]), 32'hFFFF);
        chk("l2_addr16", 32'(addr_log[16]), 32'h0000);

        // two objects, memory with two wait cycles
        wait_n = 2;
        new_line();
        hdr(16'h2000, 5'd2, 3'd1, 8'h20, 1'b1, 1'b0);
        hdr(16'h3000, 5'd1, 3'd2, 8'h40, 1'b0, 1'b1);
        wait_idle();
        queues_empty();
        chk("l3_pix_count", 32'(pix_log.size()), 3);
        chk("l3_wait", 32'(ack_log[0] - req_log[0]), 2);
        chk("l3_second_acc", 32'(acc_log[1] - pix_log[1]), 1);
        chk("l3_second_load", 32'(load_log[1] - pix_log[1]), 2);

        // budget of 40 bytes: 32 + 8 of the next, third header drained
        wait_n = 0;
        new_line();
        hdr(16'h4000, 5'd0, 3'd3, 8'h08, 1'b0, 1'b0);
        hdr(16'h5000, 5'd10, 3'd4, 8'h30, 1'b1, 1'b0);
        hdr(16'h6000, 5'd5, 3'd6, 8'h60, 1'b0, 1'b1);
        wait_idle();
        queues_empty();
        chk("l4_pix_count", 32'(pix_log.size()), BUDGET);
        chk("l4_loads", 32'(load_log.size()), 2);
        chk("l4_accepted", 32'(acc_log.size()), 3);
        chk("l4_budget_hit", 32'(BUDGET_HIT), 1);
        chk("l4_done", 32'(HDR_READY), 0);

        // overrun while a fetch is still waiting for its ack
        wait_n = 3;
        new_line();
        tick();
        chk("budget_cleared", 32'(BUDGET_HIT), 0);
        exp_load.push_back({8'h50, 3'd3, 1'b1});
        exp_fetch.push_back(16'h7000);
        send(16'h7000, 5'd4, 3'd3, 8'h50, 1'b1, 1'b1);
        tick();
        swap_log.delete();
        LINE_START = 1'b1;
        tick();
        LINE_START = 1'b0;
        wait_idle();
        queues_empty();
        chk("l5_overrun", 32'(OVERRUN), 1);
        chk("l5_no_pix", 32'(pix_log.size()), 0);
        chk("l5_swap_after_ack", 32'(swap_log[0] - ack_log[0]), 1);

        // DMA disabled in IDLE with a header waiting
        acc_log.delete(); req_log.delete(); swap_log.delete();
        DMA_EN = 1'b0;
        HDR_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("dma_off_ready", 32'(HDR_READY), 0);
        end
        LINE_START = 1'b1;
        tick();
        LINE_START = 1'b0;
        repeat (3) tick();
        chk("dma_off_no_req", 32'(req_log.size()), 0);
        chk("dma_off_no_acc", 32'(acc_log.size()), 0);
        chk("dma_off_swap", 32'(swap_log.size()), 1);
        chk("overrun_sticky", 32'(OVERRUN), 1);
        HDR_VALID = 1'b0;
        DMA_EN = 1'b1;

        // reset in the middle of a fetch
        exp_load.push_back({8'h70, 3'd1, 1'b0});
        send(16'h8000, 5'd4, 3'd1, 8'h70, 1'b0, 1'b1);
        tick();
        chk("mid_req", 32'(MEM_REQ), 1);
        RESET = 1'b1;
        #1;
        chk("mid_rst_ctl", 32'({MEM_REQ, BUSY, OVERRUN, BUDGET_HIT, PIXELS_W}), 0);
        tick();
        RESET = 1'b0;
        exp_fetch.delete();
        tick();
        chk("post_rst_done", 32'({HDR_READY, BUSY}), 0);
        queues_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
